// File: rtl/signed_mult_seq.sv
// signed_mult_seq: sequential radix-2 Booth signed multiplier.
// start/busy/done handshake: start is sampled only in IDLE, busy is high for
// the WIDTH iteration cycles, and done pulses for one cycle when product is
// updated. product holds its value until the next done (or reset).
// Optional macro SMUL_EARLY_ZERO_EN: a zero operand skips the iteration and
// completes with done in the cycle after the load edge.
module signed_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;       // multiplicand latched at load
  logic [WIDTH:0]   acc;     // one extra bit so A - (-2^(W-1)) cannot overflow
  logic [WIDTH-1:0] q;       // multiplier, shifted out LSB first
  logic             q_m1;    // Booth bit to the right of q[0]
  logic [CW-1:0]    count;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             zero_op;

  // One Booth step: add/subtract the multiplicand, then arithmetic shift right
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    sum   = acc;
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh   = {sum[0], q[WIDTH-1:1]};
  end

  // Zero-operand shortcut detection (only active when the feature is built in)
  always_comb begin
`ifdef SMUL_EARLY_ZERO_EN
    zero_op = (a == '0) || (b == '0);
`else
    zero_op = 1'b0;
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            if (zero_op) begin
              product <= '0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc   <= acc_sh;
          q     <= q_sh;
          q_m1  <= q[0];
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            product <= {acc_sh[WIDTH-1:0], q_sh};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
